// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic measurement scheduler: FSM encoding
// and the ranger's reserved distance/state codes.
package ultrasonic_pkg;

  localparam int DIST_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HOLD   = 3'd5
  } state_e;

  localparam logic [DIST_W-1:0] US_DIST_OOR   = 9'h1FF;
  localparam logic [2:0]        US_STATE_IDLE = 3'b000;

endpackage

// File: rtl/moving_avg.sv
// Power-of-two moving average over a ring of samples with a running sum;
// the first sample after reset fills the whole window.
module moving_avg
  import ultrasonic_pkg::*;
#(
  parameter int DATA_W   = DIST_W,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              load_i,
  output logic [DATA_W-1:0] avg_o,
  output logic              avg_vld_o
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;

  logic [DATA_W-1:0]   ring_q [DEPTH];
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_d;
  logic [AVG_LOG2-1:0] ptr_q;
  logic                primed_q;

  // Sum width holds DEPTH full-scale samples, so this never wraps.
  always_comb begin
    if (!primed_q) begin
      sum_d = {sample_i, {AVG_LOG2{1'b0}}};
    end else begin
      sum_d = sum_q - {{AVG_LOG2{1'b0}}, ring_q[ptr_q]} + {{AVG_LOG2{1'b0}}, sample_i};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
      sum_q     <= '0;
      ptr_q     <= '0;
      primed_q  <= 1'b0;
      avg_o     <= '0;
      avg_vld_o <= 1'b0;
    end else begin
      avg_vld_o <= load_i;
      if (load_i) begin
        sum_q    <= sum_d;
        avg_o    <= sum_d[SUM_W-1:AVG_LOG2];
        primed_q <= 1'b1;
        if (!primed_q) begin
          for (int i = 0; i < DEPTH; i++) begin
            ring_q[i] <= sample_i;
          end
        end else begin
          ring_q[ptr_q] <= sample_i;
          ptr_q         <= ptr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Free-running prescaler: tick_o is high for one clk every CLK_PER_US clks,
// phase fixed by reset release.
module tick_gen #(
  parameter int CLK_PER_US = 100
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap   = (cnt_q == CW'(CLK_PER_US - 1));
  assign tick_o = wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Periodic HC-SR04 measurement controller: start sequencing, timeout watch,
// moving-average filtering, hysteresis presence flag and error counting.
module ultrasonic_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int CLK_PER_US = 100,
  parameter int PERIOD_US  = 120_000,
  parameter int TIMEOUT_US = 60_000,
  parameter int AVG_LOG2   = 2,
  parameter int NEAR_CM    = 10,
  parameter int FAR_CM     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              single,
  output logic              us_start,
  input  logic              us_done,
  input  logic [DIST_W-1:0] us_distance,
  input  logic [2:0]        us_state,
  output logic [DIST_W-1:0] dist_avg,
  output logic              dist_valid,
  output logic              present,
  output logic              timeout,
  output logic [7:0]        err_count,
  output logic              busy
);

  localparam int PW = $clog2(PERIOD_US + 1);
  localparam int TW = $clog2(TIMEOUT_US + 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e            state_q, state_d;
  logic [PW-1:0]     per_cnt_q, per_cnt_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [DIST_W-1:0] sample_q, sample_d;
  logic              us_done_q;
  logic              tick;
  logic              done_edge;
  logic              to_hit;
  logic              per_hit;
  logic              to_fire;
  logic              err_inc;
  logic              oor_clr;
  logic              avg_load;
  logic              us_start_q, timeout_q, present_q, busy_q;
  logic [7:0]        err_q;
  logic [DIST_W-1:0] avg;
  logic              avg_vld;

  tick_gen #(
    .CLK_PER_US(CLK_PER_US)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  moving_avg #(
    .DATA_W   (DIST_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk       (clk),
    .reset     (reset),
    .sample_i  (sample_q),
    .load_i    (avg_load),
    .avg_o     (avg),
    .avg_vld_o (avg_vld)
  );

  assign done_edge = us_done & ~us_done_q;
  assign to_hit    = tick && (to_cnt_q == TW'(TIMEOUT_US - 1));
  assign per_hit   = tick && (per_cnt_q == PW'(PERIOD_US - 1));

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    to_cnt_d  = to_cnt_q;
    sample_d  = sample_q;
    to_fire   = 1'b0;
    err_inc   = 1'b0;
    oor_clr   = 1'b0;
    avg_load  = 1'b0;

    if (tick && (per_cnt_q != PW'(PERIOD_US - 1))) per_cnt_d = per_cnt_q + 1'b1;
    if (tick && (to_cnt_q != TW'(TIMEOUT_US - 1))) to_cnt_d = to_cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (enable || single) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (us_state == US_STATE_IDLE) state_d = ST_START;
      end
      ST_START: begin
        per_cnt_d = '0;
        to_cnt_d  = '0;
        state_d   = ST_WAIT;
      end
      // A done edge in the same cycle as timeout expiry takes precedence.
      ST_WAIT: begin
        if (done_edge) begin
          sample_d = us_distance;
          state_d  = ST_UPDATE;
        end else if (to_hit) begin
          to_fire = 1'b1;
          err_inc = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_UPDATE: begin
        if (sample_q == US_DIST_OOR) begin
          err_inc = 1'b1;
          oor_clr = 1'b1;
        end else begin
          avg_load = 1'b1;
        end
        state_d = ST_HOLD;
      end
      // With enable low (single shot or enable dropped) there is no period to honour.
      ST_HOLD: begin
        if (!enable)      state_d = ST_IDLE;
        else if (per_hit) state_d = ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      per_cnt_q  <= '0;
      to_cnt_q   <= '0;
      us_done_q  <= 1'b0;
      us_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      present_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      to_cnt_q   <= to_cnt_d;
      us_done_q  <= us_done;
      us_start_q <= (state_d == ST_START);
      timeout_q  <= to_fire;
      busy_q     <= (state_d != ST_IDLE);
      if (err_inc) err_q <= sat_inc(err_q);
      if (oor_clr) begin
        present_q <= 1'b0;
      end else if (avg_vld) begin
        if (avg < DIST_W'(NEAR_CM))      present_q <= 1'b1;
        else if (avg >= DIST_W'(FAR_CM)) present_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    sample_q <= sample_d;
  end

  assign us_start   = us_start_q;
  assign timeout    = timeout_q;
  assign present    = present_q;
  assign busy       = busy_q;
  assign err_count  = err_q;
  assign dist_avg   = avg;
  assign dist_valid = avg_vld;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Bench for ultrasonic_scheduler: behavioural ranger plus a window-of-samples
// reference model for average, presence and error count.
module tb_ultrasonic_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       single;
  logic       us_start;
  logic       us_done;
  logic [8:0] us_distance;
  logic [2:0] us_state;
  logic [8:0] dist_avg;
  logic       dist_valid;
  logic       present;
  logic       timeout;
  logic [7:0] err_count;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ranger model controls and observations
  logic [8:0] next_dist;
  bit         silent;
  int         resp_delay;
  bit         rng_busy;
  bit         force_busy;
  int         start_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         dv_cnt = 0;
  int         prev_t0 = -1;

  // reference model state
  logic [8:0] win[$];
  logic [8:0] exp_avg;
  bit         exp_present;
  int         exp_err;

  ultrasonic_scheduler #(
    .CLK_PER_US(2), .PERIOD_US(200), .TIMEOUT_US(100),
    .AVG_LOG2(2), .NEAR_CM(10), .FAR_CM(15)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .single(single),
    .us_start(us_start), .us_done(us_done), .us_distance(us_distance),
    .us_state(us_state), .dist_avg(dist_avg), .dist_valid(dist_valid),
    .present(present), .timeout(timeout), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dist_valid === 1'b1) dv_cnt++;

  assign us_state = (rng_busy ? 3'b011 : 3'b000) | (force_busy ? 3'b100 : 3'b000);

  initial begin
    rng_busy = 0;
    us_done = 0;
    us_distance = '0;
    forever begin
      @(negedge clk);
      if (us_start === 1'b1) begin
        start_cnt++;
        rng_busy = 1;
        repeat (resp_delay) @(negedge clk);
        if (!silent) begin
          us_distance = next_dist;
          us_done = 1;
          done_cyc = cyc;
          done_cnt++;
          repeat (3) @(negedge clk);
          us_done = 0;
        end
        rng_busy = 0;
      end
    end
  end

  task automatic ref_reset();
    win.delete();
    exp_avg = '0;
    exp_present = 0;
    exp_err = 0;
  endtask

  task automatic ref_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic ref_sample(input logic [8:0] d, input bit sil, output bit vld);
    int s;
    vld = 0;
    if (sil) begin
      ref_err();
    end else if (d == 9'h1FF) begin
      exp_present = 0;
      ref_err();
    end else begin
      if (win.size() == 0) repeat (4) win.push_back(d);
      else begin
        void'(win.pop_front());
        win.push_back(d);
      end
      s = 0;
      foreach (win[k]) s += int'(win[k]);
      exp_avg = 9'(s / 4);
      vld = 1;
      if (exp_avg < 10) exp_present = 1;
      else if (exp_avg >= 15) exp_present = 0;
    end
  endtask

  task automatic observe(input logic [8:0] d, input bit sil, output bit started, output int t0,
                         output bit got_v, output logic [8:0] avg, output bit got_to, output int lat);
    int dc0;
    next_dist = d;
    silent = sil;
    started = 0; got_v = 0; got_to = 0; avg = '0; lat = -1; t0 = -1;
    for (int i = 0; i < 1500 && !started; i++) begin
      @(negedge clk);
      if (us_start === 1'b1) begin
        started = 1;
        t0 = cyc;
      end
    end
    if (started) begin
      dc0 = done_cnt;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (dist_valid === 1'b1) begin
          got_v = 1; avg = dist_avg; lat = cyc - done_cyc;
          break;
        end
        if (timeout === 1'b1) begin
          got_to = 1; lat = cyc - t0;
          break;
        end
        if (done_cnt != dc0 && cyc >= done_cyc + 5) break;
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; single = 0; force_busy = 0;
    silent = 0; resp_delay = 6; next_dist = '0;
    ref_reset();
    repeat (4) @(negedge clk);
    checks++;
    if ({us_start, dist_valid, present, timeout, busy, dist_avg, err_count} !== 22'd0) begin
      errors++;
      $display("FAIL reset_values: got %h expected 0",
               {us_start, dist_valid, present, timeout, busy, dist_avg, err_count});
    end
    reset = 0;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || start_cnt != 0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b starts=%0d expected busy=0 starts=0", busy, start_cnt);
    end
  endtask

  task automatic test_enable_basic();
    bit st, gv, gt, ev;
    int t0, lat;
    logic [8:0] av;
    enable = 1;
    observe(9'd40, 0, st, t0, gv, av, gt, lat);
    ref_sample(9'd40, 0, ev);
    checks++;
    if (!st || !gv || av !== exp_avg) begin
      errors++;
      $display("FAIL first_avg: started=%b valid=%b avg=%0d expected valid avg=%0d", st, gv, av, exp_avg);
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL valid_latency: got %0d clks expected 2", lat);
    end
    checks++;
    if (present !== exp_present || err_count !== 8'(exp_err)) begin
      errors++;
      $display("FAIL first_flags: present=%b err=%0d expected present=%b err=%0d",
               present, err_count, exp_present, exp_err);
    end
    prev_t0 = t0;
  endtask

  task automatic test_avg_sequence();
    logic [8:0] seq [8] = '{9'd8, 9'd8, 9'd8, 9'd8, 9'd12, 9'd20, 9'd20, 9'd20};
    bit st, gv, gt, ev;
    int t0, lat;
    logic [8:0] av;
    for (int i = 0; i < 8; i++) begin
      observe(seq[i], 0, st, t0, gv, av, gt, lat);
      ref_sample(seq[i], 0, ev);
      checks++;
      if (!gv || av !== exp_avg) begin
        errors++;
        $display("FAIL avg_seq[%0d]: valid=%b avg=%0d expected avg=%0d", i, gv, av, exp_avg);
      end
      checks++;
      if (present !== exp_present) begin
        errors++;
        $display("FAIL present_seq[%0d]: got %b expected %b", i, present, exp_present);
      end
      checks++;
      if (t0 - prev_t0 < 398 || t0 - prev_t0 > 406) begin
        errors++;
        $display("FAIL period[%0d]: got %0d clks expected 398..406", i, t0 - prev_t0);
      end
      prev_t0 = t0;
    end
  endtask

  task automatic test_timeout();
    bit st, gv, gt, ev;
    int t0, lat;
    logic [8:0] av;
    observe(9'd0, 1, st, t0, gv, av, gt, lat);
    ref_sample(9'd0, 1, ev);
    checks++;
    if (!gt || gv || lat < 196 || lat > 206) begin
      errors++;
      $display("FAIL timeout_pulse: seen=%b valid=%b after %0d clks expected pulse at 196..206",
               gt, gv, lat);
    end
    checks++;
    if (err_count !== 8'(exp_err) || dist_avg !== exp_avg) begin
      errors++;
      $display("FAIL timeout_state: err=%0d avg=%0d expected err=%0d avg=%0d",
               err_count, dist_avg, exp_err, exp_avg);
    end
    prev_t0 = t0;
    observe(9'd30, 0, st, t0, gv, av, gt, lat);
    ref_sample(9'd30, 0, ev);
    checks++;
    if (t0 - prev_t0 < 398 || t0 - prev_t0 > 406 || av !== exp_avg) begin
      errors++;
      $display("FAIL after_timeout: gap=%0d avg=%0d expected gap 398..406 avg=%0d",
               t0 - prev_t0, av, exp_avg);
    end
    prev_t0 = t0;
  endtask

  task automatic test_oor();
    bit st, gv, gt, ev;
    int t0, lat;
    logic [8:0] av;
    for (int i = 0; i < 4; i++) begin
      observe(9'd3, 0, st, t0, gv, av, gt, lat);
      ref_sample(9'd3, 0, ev);
    end
    checks++;
    if (present !== 1'b1 || exp_present != 1 || dist_avg !== exp_avg) begin
      errors++;
      $display("FAIL near_present: present=%b avg=%0d expected present=1 avg=%0d", present, dist_avg, exp_avg);
    end
    observe(9'h1FF, 0, st, t0, gv, av, gt, lat);
    ref_sample(9'h1FF, 0, ev);
    checks++;
    if (gv || dist_avg !== exp_avg || present !== 1'b0 || err_count !== 8'(exp_err)) begin
      errors++;
      $display("FAIL oor_sample: valid=%b avg=%0d present=%b err=%0d expected valid=0 avg=%0d present=0 err=%0d",
               gv, dist_avg, present, err_count, exp_avg, exp_err);
    end
    prev_t0 = t0;
  endtask

  task automatic test_random();
    bit st, gv, gt, ev, sil;
    int t0, lat, r;
    logic [8:0] av, d;
    for (int i = 0; i < 16; i++) begin
      r = int'($urandom_range(0, 9));
      sil = (r == 1);
      d = (r == 0) ? 9'h1FF : (r == 2) ? 9'h1FE : 9'($urandom_range(0, 40));
      observe(d, sil, st, t0, gv, av, gt, lat);
      ref_sample(d, sil, ev);
      checks++;
      if (gv != ev || gt != sil || (ev && av !== exp_avg) || dist_avg !== exp_avg) begin
        errors++;
        $display("FAIL rand[%0d] d=%0d sil=%b: valid=%b to=%b avg=%0d expected valid=%b to=%b avg=%0d",
                 i, d, sil, gv, gt, dist_avg, ev, sil, exp_avg);
      end
      checks++;
      if (present !== exp_present || err_count !== 8'(exp_err)) begin
        errors++;
        $display("FAIL rand_flags[%0d]: present=%b err=%0d expected present=%b err=%0d",
                 i, present, err_count, exp_present, exp_err);
      end
      checks++;
      if (t0 - prev_t0 < 398 || t0 - prev_t0 > 406) begin
        errors++;
        $display("FAIL rand_period[%0d]: got %0d clks expected 398..406", i, t0 - prev_t0);
      end
      prev_t0 = t0;
    end
  endtask

  task automatic test_reset_mid();
    bit st;
    int s0;
    st = 0;
    next_dist = 9'd25;
    silent = 0;
    resp_delay = 60;
    for (int i = 0; i < 1500 && !st; i++) begin
      @(negedge clk);
      if (us_start === 1'b1) st = 1;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (!st || busy !== 1'b1 || dist_avg === 9'd0) begin
      errors++;
      $display("FAIL pre_reset_wait: started=%b busy=%b avg=%0d expected started busy avg nonzero",
               st, busy, dist_avg);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({us_start, dist_valid, present, timeout, busy, dist_avg, err_count} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0",
               {us_start, dist_valid, present, timeout, busy, dist_avg, err_count});
    end
    enable = 0;
    ref_reset();
    prev_t0 = -1;
    repeat (5) @(negedge clk);
    reset = 0;
    s0 = start_cnt;
    repeat (100) @(negedge clk);
    checks++;
    if (start_cnt != s0 || busy !== 1'b0 || dist_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: starts=%0d busy=%b expected starts=%0d busy=0", start_cnt, busy, s0);
    end
    resp_delay = 6;
  endtask

  task automatic test_single();
    bit st, gv, gt, ev;
    int t0, lat, s0, rel;
    logic [8:0] av;
    force_busy = 1;
    s0 = start_cnt;
    @(negedge clk) single = 1;
    @(negedge clk) single = 0;
    repeat (30) @(negedge clk);
    checks++;
    if (start_cnt != s0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_armed: starts=%0d busy=%b expected starts=%0d busy=1", start_cnt, busy, s0);
    end
    force_busy = 0;
    rel = cyc;
    observe(9'd12, 0, st, t0, gv, av, gt, lat);
    ref_sample(9'd12, 0, ev);
    checks++;
    if (!st || t0 - rel < 1 || t0 - rel > 2 || !gv || av !== exp_avg) begin
      errors++;
      $display("FAIL single_run: started=%b delay=%0d valid=%b avg=%0d expected delay 1..2 avg=%0d",
               st, t0 - rel, gv, av, exp_avg);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b expected 0", busy);
    end
    s0 = start_cnt;
    repeat (600) @(negedge clk);
    checks++;
    if (start_cnt != s0) begin
      errors++;
      $display("FAIL single_once: extra starts=%0d expected 0", start_cnt - s0);
    end
  endtask

  task automatic test_saturate();
    bit st, gv, gt, ev;
    int t0, lat, dv0;
    logic [8:0] av;
    dv0 = dv_cnt;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk) single = 1;
      @(negedge clk) single = 0;
      observe(9'h1FF, 0, st, t0, gv, av, gt, lat);
      ref_sample(9'h1FF, 0, ev);
      if (i == 99) begin
        checks++;
        if (err_count !== 8'(exp_err)) begin
          errors++;
          $display("FAIL err_mid: got %0d expected %0d", err_count, exp_err);
        end
      end
    end
    checks++;
    if (err_count !== 8'hFF || exp_err != 255) begin
      errors++;
      $display("FAIL err_saturate: got %0d expected 255", err_count);
    end
    checks++;
    if (dv_cnt != dv0 || dist_avg !== exp_avg || present !== 1'b0) begin
      errors++;
      $display("FAIL oor_no_valid: valids=%0d avg=%0d present=%b expected 0 valids avg=%0d present=0",
               dv_cnt - dv0, dist_avg, present, exp_avg);
    end
  endtask

  initial begin
    test_reset();
    test_enable_basic();
    test_avg_sequence();
    test_timeout();
    test_oor();
    test_random();
    test_reset_mid();
    test_single();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
